// File: rtl/nibble_adder_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built around one external 4-bit adder.
// Operands are captured on an accepted start, then one nibble per clock is
// presented to the adder, LSB first, with the carry registered between passes.
// Subtraction is A + ~B + 1: B is inverted on the way out and the +1 enters as
// the initial carry. A single-cycle done pulse marks the result as valid.
module nibble_adder_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       adder_a,
  output logic [3:0]       adder_b,
  output logic             adder_c0,
  input  logic [3:0]       adder_s,
  input  logic             adder_c4
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastNib = CntW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             run;

  assign run = (state_q == StRun);

  // Select the operand nibbles addressed by the pass counter.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (cnt_q == CntW'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
  end

  // Drive the shared adder only while running; otherwise keep its inputs quiet.
  always_comb begin
    adder_a  = '0;
    adder_b  = '0;
    adder_c0 = 1'b0;
    if (run) begin
      adder_a  = nib_a;
      adder_b  = nib_b ^ {4{sub_q}};
      adder_c0 = carry_q;
    end
  end

  // Next-state logic: operand capture, per-nibble result assembly, flag update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          a_d      = op_a;
          b_d      = op_b;
          sub_d    = sub;
          cnt_d    = '0;
          // Initial carry supplies the +1 of the two's-complement negate.
          carry_d  = sub;
          result_d = '0;
        end
      end
      StRun: begin
        for (int k = 0; k < NIBBLES; k++) begin
          if (cnt_q == CntW'(k)) begin
            result_d[4*k +: 4] = adder_s;
          end
        end
        carry_d = adder_c4;
        if (cnt_q == LastNib) begin
          state_d     = StDone;
          cnt_d       = '0;
          carry_out_d = adder_c4;
          // Carry into the MSB recovered from the top nibble's bit-3 sum.
          overflow_d  = adder_c4 ^ (adder_a[3] ^ adder_b[3] ^ adder_s[3]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // Handshake and result outputs decoded from state and held registers.
  always_comb begin
    ready     = (state_q == StIdle);
    busy      = run;
    done      = (state_q == StDone);
    result    = result_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_nibble_adder_sequencer.sv
// Scoreboard bench for nibble_adder_sequencer with WIDTH=16 and a behavioural
// 4-bit carry-lookahead adder closing the loop on the adder ports.
module tb_nibble_adder_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;
  localparam int NV = 7;

  localparam logic [15:0] TV_A   [NV] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000,
                                          16'h0003, 16'h00FF, 16'hA5A5};
  localparam logic [15:0] TV_B   [NV] = '{16'h0FCD, 16'h0001, 16'h0001, 16'h0001,
                                          16'h0005, 16'h0F01, 16'hA5A5};
  localparam logic        TV_S   [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [15:0] TV_R   [NV] = '{16'h2201, 16'h0000, 16'h8000, 16'h7FFF,
                                          16'hFFFE, 16'h1000, 16'h0000};
  localparam logic        TV_CO  [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic        TV_OV  [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        ready, busy, done, carry_out, overflow, adder_c0, adder_c4;
  logic [15:0] result;
  logic [3:0]  adder_a, adder_b, adder_s;

  nibble_adder_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .adder_a  (adder_a),
    .adder_b  (adder_b),
    .adder_c0 (adder_c0),
    .adder_s  (adder_s),
    .adder_c4 (adder_c4)
  );

  always #5 clk = ~clk;

  // 4-bit carry-lookahead adder
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g    = adder_a & adder_b;
    p    = adder_a ^ adder_b;
    c[0] = adder_c0;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
  end
  assign adder_s  = p ^ c[3:0];
  assign adder_c4 = c[4];

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic [31:0] stamp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        acc_e;
  exp_t        mon_e;
  logic [15:0] exp_res = '0;
  logic        exp_co = 1'b0;
  logic        exp_ov = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          done_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Acceptor: an accepted start pushes the expected response.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && ready && start) begin
      acc_e.res   = exp_res;
      acc_e.co    = exp_co;
      acc_e.ov    = exp_ov;
      acc_e.stamp = cyc;
      exp_q.push_back(acc_e);
    end
  end

  // Monitor: every done pulse pops and compares one expected response.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: result 0x%0h with no operation pending", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {16'h0, result}, {16'h0, mon_e.res});
        check("carry_out", {31'h0, carry_out}, {31'h0, mon_e.co});
        check("overflow", {31'h0, overflow}, {31'h0, mon_e.ov});
        check("latency", cyc - mon_e.stamp, NIB);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'h0, ready}, 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] r, input logic co, input logic ov);
    wait_ready();
    op_a    = a;
    op_b    = b;
    sub     = s;
    exp_res = r;
    exp_co  = co;
    exp_ov  = ov;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {31'h0, ready}, 32'h1);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_result"}, {16'h0, result}, 32'h0);
    check({tag, "_adder"}, {23'h0, adder_a, adder_b, adder_c0}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c0_seq;
    int d0;
    c0_seq = 4'b1110;

    #3;
    check_quiet("reset");
    check("reset_carry_out", {31'h0, carry_out}, 32'h0);
    check("reset_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First vector: also trace the carry-in handed to the adder per nibble.
    issue(TV_A[0], TV_B[0], TV_S[0], TV_R[0], TV_CO[0], TV_OV[0]);
    for (int k = 0; k < 4; k++) begin
      check("run_busy", {31'h0, busy}, 32'h1);
      check("c0_seq", {31'h0, adder_c0}, {31'h0, c0_seq[k]});
      @(negedge clk);
    end
    drain();

    for (int i = 1; i < NV; i++) begin
      issue(TV_A[i], TV_B[i], TV_S[i], TV_R[i], TV_CO[i], TV_OV[i]);
      drain();
    end

    // Result fields hold after done.
    repeat (3) @(negedge clk);
    check("hold_result", {16'h0, result}, 32'h0);
    check("hold_carry_out", {31'h0, carry_out}, 32'h1);
    check("idle_adder_quiet", {23'h0, adder_a, adder_b, adder_c0}, 32'h0);

    // Start and operand changes during RUN are ignored.
    d0 = done_cnt;
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    op_a    = 16'hFFFF;
    op_b    = 16'hFFFF;
    sub     = 1'b1;
    exp_res = 16'hDEAD;
    exp_co  = 1'b1;
    exp_ov  = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("ignored_start_dones", done_cnt - d0, 1);

    // Start held high: done every NIB+2 cycles.
    wait_ready();
    op_a    = 16'h0101;
    op_b    = 16'h0202;
    sub     = 1'b0;
    exp_res = 16'h0303;
    exp_co  = 1'b0;
    exp_ov  = 1'b0;
    d0      = done_cnt;
    start   = 1'b1;
    for (int n = 0; n < 40 && done_cnt < d0 + 3; n++) @(negedge clk);
    start = 1'b0;
    check("b2b_count", {31'h0, done_cnt >= d0 + 3}, 32'h1);
    drain();
    if (done_cyc.size() >= d0 + 3) begin
      check("b2b_gap0", done_cyc[d0 + 1] - done_cyc[d0], NIB + 2);
      check("b2b_gap1", done_cyc[d0 + 2] - done_cyc[d0 + 1], NIB + 2);
    end

    // Asynchronous reset after two nibbles: operation dropped, no done.
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("midrun_reset");
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    drain();
    check("post_reset_dones", done_cnt - d0, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
